// File: rtl/branch_sched_pkg.sv
// Shared definitions for the branch scheduler: comparator type codes, FSM
// state encoding and the branch target helper.
package branch_sched_pkg;

  localparam logic [3:0] BR_BEQ = 4'b0001;
  localparam logic [3:0] BR_LT  = 4'b0010;
  localparam logic [3:0] BR_LE  = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CMP  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // imm counts words, so it is sign-extended and scaled by 4; the sum wraps at 32 bits
  function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_sched_sat_counter.sv
// Statistics counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_sched.sv
// Sequences the shared external branch comparator: waits for forwarded
// operands, compares, and emits a one-cycle resolution and redirect pulse.
module branch_sched
  import branch_sched_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_type,
  input  logic [31:0]      req_pc,
  input  logic [15:0]      req_imm,
  input  logic [31:0]      opnd_a,
  input  logic             opnd_a_ok,
  input  logic [31:0]      opnd_b,
  input  logic             opnd_b_ok,
  input  logic             flush,
  output logic [31:0]      cmp_a,
  output logic [31:0]      cmp_b,
  output logic [3:0]       cmp_type,
  input  logic             cmp_result,
  output logic             stall,
  output logic             done,
  output logic             taken,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] br_cnt,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_t      state, next_state;
  logic [3:0]  type_r;
  logic [31:0] pc_r;
  logic [15:0] imm_r;
  logic [31:0] a_r, b_r;
  logic        taken_r;
  logic [31:0] target_r;

  logic accept, ops_ok;

  // A flush in IDLE blocks acceptance of a simultaneous request
  assign accept = (state == S_IDLE) && req_valid && !flush;
  assign ops_ok = opnd_a_ok && opnd_b_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Operands are captured only as a complete pair, never one at a time
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      type_r   <= '0;
      pc_r     <= '0;
      imm_r    <= '0;
      a_r      <= '0;
      b_r      <= '0;
      taken_r  <= 1'b0;
      target_r <= '0;
    end else begin
      if (accept) begin
        type_r <= req_type;
        pc_r   <= req_pc;
        imm_r  <= req_imm;
      end
      if ((accept || (state == S_WAIT)) && ops_ok) begin
        a_r <= opnd_a;
        b_r <= opnd_b;
      end
      if (state == S_CMP) begin
        taken_r  <= cmp_result;
        target_r <= branch_target(pc_r, imm_r);
      end
    end
  end

  always_comb begin
    next_state     = state;
    req_ready      = 1'b0;
    stall          = 1'b0;
    done           = 1'b0;
    taken          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    cmp_a          = '0;
    cmp_b          = '0;
    cmp_type       = '0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (accept) begin
          next_state = ops_ok ? S_CMP : S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (flush) begin
          next_state = S_IDLE;
        end else if (ops_ok) begin
          next_state = S_CMP;
        end
      end
      S_CMP: begin
        stall      = 1'b1;
        cmp_a      = a_r;
        cmp_b      = b_r;
        cmp_type   = type_r;
        next_state = flush ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        done           = 1'b1;
        taken          = taken_r;
        redirect_valid = taken_r;
        redirect_pc    = taken_r ? target_r : 32'd0;
        next_state     = S_IDLE;
      end
      default: next_state = S_IDLE;
    endcase
  end

  // A flushed WAIT cycle is abandoned work, so it is not counted as a stall
  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (state == S_DONE),
    .count (br_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_taken_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == S_DONE) && taken_r),
    .count (taken_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   ((state == S_WAIT) && !flush),
    .count (stall_cnt)
  );

endmodule

// File: tb/tb_branch_sched.sv
// Self-checking bench for branch_sched: vector table plus scoreboard, with
// hand-written flush, saturation and reset sequences.
module tb_branch_sched;
  import branch_sched_pkg::*;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_type;
  logic [31:0]      req_pc;
  logic [15:0]      req_imm;
  logic [31:0]      opnd_a;
  logic             opnd_a_ok;
  logic [31:0]      opnd_b;
  logic             opnd_b_ok;
  logic             flush;
  logic [31:0]      cmp_a;
  logic [31:0]      cmp_b;
  logic [3:0]       cmp_type;
  logic             cmp_result;
  logic             stall;
  logic             done;
  logic             taken;
  logic             redirect_valid;
  logic [31:0]      redirect_pc;
  logic [CNT_W-1:0] br_cnt;
  logic [CNT_W-1:0] taken_cnt;
  logic [CNT_W-1:0] stall_cnt;

  typedef struct {
    logic [3:0]  br_type;
    logic [31:0] pc;
    logic [15:0] imm;
    logic [31:0] a;
    logic [31:0] b;
    int          wait_cycles;
    logic        exp_taken;
    logic [31:0] exp_pc;
  } vec_t;

  typedef struct {
    logic        taken;
    logic [31:0] pc;
  } exp_t;

  vec_t vecs[8];
  exp_t sb_q[$];
  int   checks;
  int   failures;
  int   exp_br;
  int   exp_tk;
  int   exp_st;

  branch_sched #(.CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_type       (req_type),
    .req_pc         (req_pc),
    .req_imm        (req_imm),
    .opnd_a         (opnd_a),
    .opnd_a_ok      (opnd_a_ok),
    .opnd_b         (opnd_b),
    .opnd_b_ok      (opnd_b_ok),
    .flush          (flush),
    .cmp_a          (cmp_a),
    .cmp_b          (cmp_b),
    .cmp_type       (cmp_type),
    .cmp_result     (cmp_result),
    .stall          (stall),
    .done           (done),
    .taken          (taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .br_cnt         (br_cnt),
    .taken_cnt      (taken_cnt),
    .stall_cnt      (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External comparator model: anything that is not a supported one-hot code yields 0
  function automatic logic comparator(input logic [3:0] t, input logic [31:0] a,
                                      input logic [31:0] b);
    case (t)
      BR_BEQ:  return a == b;
      BR_LT:   return $signed(a) < $signed(b);
      BR_LE:   return $signed(a) <= $signed(b);
      default: return 1'b0;
    endcase
  endfunction

  assign cmp_result = comparator(cmp_type, cmp_a, cmp_b);

  function automatic int sat_inc(input int v);
    return (v >= CNT_MAX) ? CNT_MAX : v + 1;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic check_counters(input string tag);
    check_output({tag, ".br_cnt"},    32'(br_cnt),    32'(exp_br));
    check_output({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(exp_tk));
    check_output({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(exp_st));
  endtask

  // Drives one branch, holds opnd_b_ok low for wait_cycles WAIT cycles, then
  // scoreboards the resolution and checks the counters once it retires.
  task automatic apply_stimulus(input vec_t v, input logic flush_in_done);
    exp_t e;
    int   cycles;
    e.taken = v.exp_taken;
    e.pc    = v.exp_pc;
    sb_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b1;
    req_type  = v.br_type;
    req_pc    = v.pc;
    req_imm   = v.imm;
    opnd_a    = v.a;
    opnd_b    = v.b;
    opnd_a_ok = 1'b1;
    opnd_b_ok = (v.wait_cycles == 0);
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= v.wait_cycles; k++) begin
      check_output("wait_stall", 32'(stall), 32'd1);
      opnd_b_ok = (k == v.wait_cycles);
      @(negedge clk);
    end
    cycles = 1;
    while (done !== 1'b1 && cycles < 8) begin
      @(negedge clk);
      cycles++;
    end
    if (done !== 1'b1) begin
      checks++;
      failures++;
      $display("[TB] FAIL done_timeout: got no done, expected done within 2 cycles");
      sb_q.delete();
    end else begin
      check_output("latency", 32'(cycles), 32'd2);
      e = sb_q.pop_front();
      check_output("taken",          32'(taken),          32'(e.taken));
      check_output("redirect_valid", 32'(redirect_valid), 32'(e.taken));
      check_output("redirect_pc",    redirect_pc,         e.pc);
      check_output("done_stall",     32'(stall),          32'd0);
      exp_br = sat_inc(exp_br);
      if (e.taken) exp_tk = sat_inc(exp_tk);
      for (int k = 0; k < v.wait_cycles; k++) exp_st = sat_inc(exp_st);
    end
    if (flush_in_done) flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("done_pulse", 32'(done), 32'd0);
    check_output("idle_ready", 32'(req_ready), 32'd1);
    check_counters("retire");
    opnd_b_ok = 1'b1;
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{BR_BEQ,  32'h0000_3000, 16'h0004, 32'd5,         32'd5,         0, 1'b1, 32'h0000_3014};
    vecs[1] = '{BR_LT,   32'h0000_3000, 16'h0004, 32'h0000_0001, 32'hFFFF_FFFF, 0, 1'b0, 32'h0000_0000};
    vecs[2] = '{BR_LT,   32'h0000_1000, 16'h0010, 32'hFFFF_FFFF, 32'h0000_0001, 3, 1'b1, 32'h0000_1044};
    vecs[3] = '{BR_LE,   32'h0000_3010, 16'hFFFC, 32'hFFFF_FFFE, 32'h0000_0000, 0, 1'b1, 32'h0000_3004};
    vecs[4] = '{4'b0011, 32'h0000_4000, 16'h0004, 32'd7,         32'd7,         0, 1'b0, 32'h0000_0000};
    vecs[5] = '{BR_BEQ,  32'h0000_5000, 16'h0001, 32'd1,         32'd2,         1, 1'b0, 32'h0000_0000};
    vecs[6] = '{BR_LE,   32'hFFFF_FFF0, 16'h0008, 32'd3,         32'd3,         0, 1'b1, 32'h0000_0014};
    vecs[7] = '{BR_BEQ,  32'h0000_2000, 16'h8000, 32'd0,         32'd0,         0, 1'b1, 32'hFFFE_2004};

    checks    = 0;
    failures  = 0;
    exp_br    = 0;
    exp_tk    = 0;
    exp_st    = 0;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_type  = '0;
    req_pc    = '0;
    req_imm   = '0;
    opnd_a    = '0;
    opnd_b    = '0;
    opnd_a_ok = 1'b0;
    opnd_b_ok = 1'b0;
    flush     = 1'b0;
    repeat (2) @(negedge clk);
    check_output("rst_req_ready",   32'(req_ready),      32'd1);
    check_output("rst_stall",       32'(stall),          32'd0);
    check_output("rst_done",        32'(done),           32'd0);
    check_output("rst_redirect",    32'(redirect_valid), 32'd0);
    check_output("rst_cmp_a",       cmp_a,               32'd0);
    check_counters("rst");
    reset = 1'b1;

    for (int i = 0; i < 8; i++) apply_stimulus(vecs[i], 1'b0);

    $display("[TB] flush while waiting for operands");
    @(negedge clk);
    req_valid = 1'b1; req_type = BR_BEQ; req_pc = 32'h100; req_imm = 16'h1;
    opnd_a = 32'd9; opnd_b = 32'd9; opnd_a_ok = 1'b1; opnd_b_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("fwait_stall", 32'(stall), 32'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("fwait_ready", 32'(req_ready), 32'd1);
    check_output("fwait_stall_off", 32'(stall), 32'd0);
    check_output("fwait_done", 32'(done), 32'd0);
    @(negedge clk);
    check_output("fwait_done2", 32'(done), 32'd0);
    check_counters("fwait");
    opnd_b_ok = 1'b1;
    v = '{BR_BEQ, 32'h0000_0200, 16'h0002, 32'd4, 32'd4, 0, 1'b1, 32'h0000_020C};
    apply_stimulus(v, 1'b0);

    $display("[TB] flush alongside a request in IDLE");
    @(negedge clk);
    req_valid = 1'b1; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check_output("fidle_ready", 32'(req_ready), 32'd1);
    check_output("fidle_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check_output("fidle_done", 32'(done), 32'd0);
    check_counters("fidle");

    $display("[TB] flush during compare");
    @(negedge clk);
    req_valid = 1'b1; req_type = BR_BEQ; opnd_a = 32'h55; opnd_b = 32'h55;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("fcmp_stall", 32'(stall), 32'd1);
    check_output("fcmp_type", 32'(cmp_type), 32'(BR_BEQ));
    check_output("fcmp_a", cmp_a, 32'h55);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check_output("fcmp_ready", 32'(req_ready), 32'd1);
    check_output("fcmp_done", 32'(done), 32'd0);
    @(negedge clk);
    check_output("fcmp_done2", 32'(done), 32'd0);
    check_counters("fcmp");

    $display("[TB] flush during the done cycle is ignored");
    v = '{BR_LT, 32'h0000_0400, 16'h0003, 32'hFFFF_FF00, 32'd0, 0, 1'b1, 32'h0000_0410};
    apply_stimulus(v, 1'b1);

    $display("[TB] saturating counters");
    for (int j = 0; j < 10; j++) begin
      v = '{BR_BEQ, 32'(j) << 8, 16'h0001, 32'(j), 32'(j), 0, 1'b1, (32'(j) << 8) + 32'd8};
      apply_stimulus(v, 1'b0);
    end

    $display("[TB] reset during compare");
    @(negedge clk);
    req_valid = 1'b1; req_type = BR_BEQ; opnd_a = 32'd1; opnd_b = 32'd1;
    @(negedge clk);
    req_valid = 1'b0;
    check_output("rcmp_stall", 32'(stall), 32'd1);
    #2 reset = 1'b0;
    #1;
    exp_br = 0;
    exp_tk = 0;
    exp_st = 0;
    check_output("rcmp_ready", 32'(req_ready), 32'd1);
    check_output("rcmp_stall_off", 32'(stall), 32'd0);
    check_output("rcmp_cmp_type", 32'(cmp_type), 32'd0);
    check_counters("rcmp");
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("rcmp_no_done", 32'(done), 32'd0);
      check_output("rcmp_idle", 32'(req_ready), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
